// File: rtl/fixed_to_fp_pipe_if.sv
// Handshake bundle between a fixed-point producer and the float converter.
// Signals: in_valid/in_ready/in_data (input side), out_valid/out_ready/out_data/out_inexact (result side).
// master = producer/consumer side (testbench or CORDIC glue); slave = the converter itself.
interface fixed_to_fp_pipe_if #(
  parameter int IN_W = 27
) ();
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/fixed_to_fp_pipe.sv
// Fixed-point (signed or unsigned, IN_W bits with FRAC_W fraction bits) to IEEE-754 binary32.
// Latency 3 cycles, 1 word/cycle; one global stall (advance = !out_valid || out_ready) freezes all stages.
// Ports: clk, rst (sync, active-high), bus (slave modport of fixed_to_fp_pipe_if).
// Macro FIXED_TO_FP_RNE_EN: defined -> round-to-nearest-even, undefined -> truncation.
// out_inexact reports discarded bits in both builds.
module fixed_to_fp_pipe #(
  parameter int IN_W      = 27,
  parameter int FRAC_W    = 23,
  parameter int SIGNED_IN = 1
) (
  input  logic               clk,
  input  logic               rst,
  fixed_to_fp_pipe_if.slave  bus
);

  logic advance;

  // Stage registers
  logic            s1_vld_q, s1_vld_d;
  logic            s1_sign_q, s1_sign_d;
  logic [IN_W-1:0] s1_mag_q, s1_mag_d;

  logic            s2_vld_q, s2_vld_d;
  logic            s2_sign_q;
  logic            s2_zero_q, s2_zero_d;
  logic [4:0]      s2_msb_q, s2_msb_d;
  logic [IN_W-2:0] s2_norm_q, s2_norm_d;   // bits below the leading one, left-aligned

  logic            out_vld_q, out_vld_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_inexact_q, out_inexact_d;

  assign advance         = !out_vld_q || bus.out_ready;
  assign bus.in_ready    = advance;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_inexact = out_inexact_q;

  // Stage 1: sign/magnitude. The most negative input negates to 2^(IN_W-1),
  // which is still representable as an unsigned IN_W-bit magnitude.
  always_comb begin
    s1_vld_d  = bus.in_valid;
    s1_sign_d = (SIGNED_IN != 0) ? bus.in_data[IN_W-1] : 1'b0;
    s1_mag_d  = s1_sign_d ? (~bus.in_data + IN_W'(1)) : bus.in_data;
  end

  // Stage 2: find the leading one and normalise.
  logic [4:0] shamt;
  always_comb begin
    s2_vld_d = s1_vld_q;
    s2_msb_d = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag_q[i]) s2_msb_d = 5'(i);
    end
    shamt     = 5'(IN_W-1) - s2_msb_d;
    // Only the bits below the leading one are kept; the leading one is implicit.
    s2_norm_d = s1_mag_q[IN_W-2:0] << shamt;
    s2_zero_d = (s1_mag_q == '0);
  end

  // Stage 3: exponent, mantissa extraction and rounding.
  logic [63:0] frac_ext;
  logic [22:0] mant, mant_r;
  logic        guard, sticky;
  logic [7:0]  exp_b, exp_r;
`ifdef FIXED_TO_FP_RNE_EN
  logic        round_up;
  logic [23:0] mant_sum;
`endif

  always_comb begin
    out_vld_d = s2_vld_q;
    // Left-align the fraction in a 64-bit field so mantissa, guard and sticky
    // are fixed slices regardless of IN_W; short inputs get zero padding.
    frac_ext  = {s2_norm_q, {(65-IN_W){1'b0}}};
    mant      = frac_ext[63:41];
    guard     = frac_ext[40];
    sticky    = |frac_ext[39:0];
    // msb <= 31 and FRAC_W <= 31 keep this within 96..158 before rounding.
    exp_b     = {3'b000, s2_msb_q} + 8'(127 - FRAC_W);
`ifdef FIXED_TO_FP_RNE_EN
    round_up  = guard && (sticky || mant[0]);
    mant_sum  = {1'b0, mant} + {23'b0, round_up};
    // On carry-out the low 23 bits are already zero, so only the exponent bumps.
    mant_r    = mant_sum[22:0];
    exp_r     = exp_b + {7'b0, mant_sum[23]};
`else
    mant_r    = mant;
    exp_r     = exp_b;
`endif
    if (s2_zero_q) begin
      out_data_d    = 32'h0000_0000;
      out_inexact_d = 1'b0;
    end else begin
      out_data_d    = {s2_sign_q, exp_r, mant_r};
      out_inexact_d = guard || sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_mag_q      <= '0;
      s2_vld_q      <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_msb_q      <= '0;
      s2_norm_q     <= '0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else if (advance) begin
      s1_vld_q      <= s1_vld_d;
      s1_sign_q     <= s1_sign_d;
      s1_mag_q      <= s1_mag_d;
      s2_vld_q      <= s2_vld_d;
      s2_sign_q     <= s1_sign_q;
      s2_zero_q     <= s2_zero_d;
      s2_msb_q      <= s2_msb_d;
      s2_norm_q     <= s2_norm_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule

// File: tb/tb_fixed_to_fp_pipe.sv
// Self-checking bench for fixed_to_fp_pipe: a signed 27/23 instance and an unsigned 16/8 instance.
// Directed vectors with hand-computed binary32 results; rounding expectations follow FIXED_TO_FP_RNE_EN.
// Covers reset state, streaming latency/throughput, backpressure ordering and mid-stream reset.
module tb_fixed_to_fp_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_to_fp_pipe_if #(.IN_W(27)) bus_a ();
  fixed_to_fp_pipe_if #(.IN_W(16)) bus_b ();

  fixed_to_fp_pipe #(.IN_W(27), .FRAC_W(23), .SIGNED_IN(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fixed_to_fp_pipe #(.IN_W(16), .FRAC_W(8), .SIGNED_IN(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One word through instance A on an idle pipe; lat counts cycles from accept to out_valid.
  task automatic convert_a(input logic [26:0] d, output logic [31:0] q, output logic ix, output int lat);
    @(negedge clk);
    bus_a.in_data   = d;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    lat = 1;
    while (!bus_a.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    q  = bus_a.out_data;
    ix = bus_a.out_inexact;
  endtask

  task automatic convert_b(input logic [15:0] d, output logic [31:0] q, output logic ix, output int lat);
    @(negedge clk);
    bus_b.in_data   = d;
    bus_b.in_valid  = 1'b1;
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    lat = 1;
    while (!bus_b.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    q  = bus_b.out_data;
    ix = bus_b.out_inexact;
  endtask

  logic [26:0] st_in  [5];
  logic [31:0] st_exp [5];
  logic [26:0] bp_in  [5];
  logic [31:0] bp_exp [5];
  logic [26:0] rv_in  [3];
  logic [31:0] rv_exp [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic        ix;
    int          lat;
    int          out_idx, in_idx, stall_left, n_stall, n_extra;
    bit          started;

    st_in[0] = 27'h0800000; st_exp[0] = 32'h3F80_0000;
    st_in[1] = 27'h7800000; st_exp[1] = 32'hBF80_0000;
    st_in[2] = 27'h4000000; st_exp[2] = 32'hC100_0000;
    st_in[3] = 27'h0000000; st_exp[3] = 32'h0000_0000;
    st_in[4] = 27'h0000001; st_exp[4] = 32'h3400_0000;

    bp_in[0] = 27'h0800000; bp_exp[0] = 32'h3F80_0000;  // 1.0
    bp_in[1] = 27'h1000000; bp_exp[1] = 32'h4000_0000;  // 2.0
    bp_in[2] = 27'h1800000; bp_exp[2] = 32'h4040_0000;  // 3.0
    bp_in[3] = 27'h0400000; bp_exp[3] = 32'h3F00_0000;  // 0.5
    bp_in[4] = 27'h7800000; bp_exp[4] = 32'hBF80_0000;  // -1.0

    rv_in[0] = 27'h1000001;
    rv_in[1] = 27'h1000003;
    rv_in[2] = 27'h3FFFFFF;
`ifdef FIXED_TO_FP_RNE_EN
    rv_exp[0] = 32'h4000_0000;
    rv_exp[1] = 32'h4000_0002;
    rv_exp[2] = 32'h4100_0000;
`else
    rv_exp[0] = 32'h4000_0000;
    rv_exp[1] = 32'h4000_0001;
    rv_exp[2] = 32'h40FF_FFFF;
`endif

    rst             = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid",   bus_a.out_valid,   0);
    check("rst_out_data",    bus_a.out_data,    0);
    check("rst_out_inexact", bus_a.out_inexact, 0);
    check("rst_in_ready",    bus_a.in_ready,    1);
    check("rst_b_out_valid", bus_b.out_valid,   0);

    // Back-to-back stream: results in cycles 3..7 after the first accept
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        check("stream_vld",  bus_a.out_valid,   1);
        check("stream_data", bus_a.out_data,    st_exp[c-3]);
        check("stream_inex", bus_a.out_inexact, 0);
      end else begin
        check("stream_idle", bus_a.out_valid, 0);
      end
      if (c < 5) begin
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = st_in[c];
        check("stream_in_ready", bus_a.in_ready, 1);
      end else begin
        bus_a.in_valid = 1'b0;
      end
    end

    // Backpressure: 4 stalled cycles after the first result
    out_idx = 0; in_idx = 0; stall_left = 0; n_stall = 0; n_extra = 0; started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!started && bus_a.out_valid) begin
        started    = 1'b1;
        stall_left = 4;
      end
      bus_a.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (bus_a.out_valid) begin
        if (out_idx < 5) check("bp_data", bus_a.out_data, bp_exp[out_idx]);
        else n_extra++;
        if (!bus_a.out_ready) begin
          n_stall++;
          check("bp_in_ready_low", bus_a.in_ready, 0);
        end else begin
          out_idx++;
        end
      end
      if (in_idx < 5) begin
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = bp_in[in_idx];
        if (bus_a.in_ready) in_idx++;
      end else begin
        bus_a.in_valid = 1'b0;
      end
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    check("bp_delivered", out_idx, 5);
    check("bp_extra",     n_extra, 0);
    check("bp_stall_cyc", n_stall, 4);

    // Rounding / truncation vectors
    for (int i = 0; i < 3; i++) begin
      convert_a(rv_in[i], q, ix, lat);
      check("round_data", q,   rv_exp[i]);
      check("round_inex", ix,  1);
      check("round_lat",  lat, 3);
    end

    // Most negative input: -2^26 / 2^23 = -8.0
    convert_a(27'h4000000, q, ix, lat);
    check("minneg_data", q, 32'hC100_0000);

    // Unsigned 16/8 instance
    convert_b(16'hFFFF, q, ix, lat);
    check("u16_ffff_data", q,   32'h437F_FF00);
    check("u16_ffff_inex", ix,  0);
    check("u16_ffff_lat",  lat, 3);
    convert_b(16'h0100, q, ix, lat);
    check("u16_one_data", q, 32'h3F80_0000);
    convert_b(16'h0000, q, ix, lat);
    check("u16_zero_data", q, 32'h0000_0000);

    // Mid-stream reset: three words accepted, then reset; nothing stale may emerge
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = bp_in[c+1];
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out_data", bus_a.out_data, 0);
    for (int c = 0; c < 6; c++) begin
      check("mrst_no_stale", bus_a.out_valid, 0);
      @(negedge clk);
    end
    convert_a(27'h0800000, q, ix, lat);
    check("mrst_new_data", q,   32'h3F80_0000);
    check("mrst_new_lat",  lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_to_fp_pipe.md
Name: fixed_to_fp_pipe

Overview:
Parametrised, pipelined successor to the combinational fixed-point to IEEE-754 single converter. It accepts signed or unsigned fixed-point words of configurable integer/fraction split and produces binary32 results. Conversion uses round-to-nearest-even, and the block raises an inexact flag. It has a 3-stage valid/ready pipeline so the CORDIC datapath can stream results into it without a long combinational path.

Parameters:
IN_W, 27, total input width in bits; legal range 8..32.
FRAC_W, 23, fraction bits of input; legal range 0..IN_W-1.
SIGNED_IN, 1, 1 = two's-complement input, 0 = unsigned magnitude.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept input this cycle
in_data  in  IN_W  fixed-point input
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  32  IEEE-754 binary32 result
out_inexact  out  1  result differs from the exact input value (bits discarded)

Behaviour:
- Reset: on rst high at a clk edge, all stage valid bits, out_valid, out_data and out_inexact clear to 0. in_ready is 1 in the cycle after reset.
- A reset asserted mid-stream discards all in-flight words. There is no partial output.
- Global stall: advance = !out_valid || out_ready. in_ready = advance (combinational). When advance is 0, all stage registers hold.
- An input transfers on in_valid && in_ready. Its result appears with out_valid high exactly 3 cycles later when there is no backpressure. Throughput is 1 word per cycle.
- out_data and out_inexact stay stable while out_valid && !out_ready.
- Bubbles propagate: a stage whose input valid is 0 loads valid = 0. Its data is don't-care.
- Stage 1: sign = SIGNED_IN ? in_data[IN_W-1] : 0. mag = sign ? (~in_data + 1) : in_data, computed as IN_W-bit unsigned. The most negative input (-2^(IN_W-1)) yields mag = 2^(IN_W-1), which is correct.
- Stage 2:
  - Leading-zero count of mag. msb = IN_W-1-lzc.
  - norm = mag left-shifted so the leading 1 sits at bit IN_W-1. zero flag = (mag == 0).
  - Register sign, msb, norm, zero.
- Stage 3:
  - exp = msb - FRAC_W + 127.
  - mantissa = the 23 bits below the leading 1, zero-padded on the right when fewer than 23 remain.
  - Dropped bits form guard (first dropped) and sticky (OR of the rest).
  - Round up if guard && (sticky || mantissa[0]).
  - A rounding carry out of the mantissa sets the mantissa to 0 and increments exp.
  - out_inexact = guard || sticky.
  - out_data = {sign, exp[7:0], mantissa}.
- Zero input: out_data = 32'h0000_0000, out_inexact = 0. -0 cannot be produced.
- Range: for the legal parameters, exp stays within 96..159. No infinity, denormal or NaN output is ever produced and no saturation logic is required.
- If msb <= 23, the result is exact and out_inexact = 0.

Optional Feature:
Macro FIXED_TO_FP_RNE_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncation. Dropped bits are discarded with no increment and no exponent carry. out_inexact is still reported as guard || sticky.
- Latency and handshake are identical in both builds.

Test Plan:
- IN_W=27, FRAC_W=23, RNE build. Stream 0x0800000, 0x7800000, 0x4000000, 0x0000000, 0x0000001 on consecutive cycles, out_ready=1 -> outputs 0x3F800000, 0xBF800000, 0xC1000000, 0x00000000, 0x34000000 on cycles 3..7 after the first accept, all inexact=0.
- Rounding, RNE build:
  - 0x1000001 -> 0x40000000 inexact=1 (tie, round to even).
  - 0x1000003 -> 0x40000002 inexact=1.
  - 0x3FFFFFF -> 0x41000000 inexact=1 (carry bumps exponent).
- Truncation build: 0x3FFFFFF -> 0x40FFFFFF inexact=1; 0x1000003 -> 0x40000001.
- Backpressure: stream 5 words, hold out_ready=0 for 4 cycles after the first out_valid -> in_ready drops, out_data holds. All 5 results are delivered in order with none lost or duplicated once out_ready=1.
- Reset mid-stream: assert rst for 1 cycle with 3 words in flight -> out_valid=0 the next cycle and no stale result ever appears. A new input 0x0800000 yields 0x3F800000 three cycles after acceptance.
- SIGNED_IN=0, IN_W=16, FRAC_W=8: 0xFFFF -> 0x437FFF00 (255.99609375, exact); 0x0100 -> 0x3F800000.
